// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Control sequencer for a small program-counter / ROM pipeline. It holds
// the PC stage in init until a host start request, then decodes each
// 9-bit instruction word presented by the ROM stage and steers the PC with
// branch/jump/address. A run ends on HALT or when the RUN-cycle watchdog
// reaches MAX_CYCLES.
//
// Instruction decode: opcode = Instruction[8:5], idx = Instruction[4:0]
//   4'hF HALT  end of program
//   4'hE BR    taken when flag is set
//   4'hD JMP   always taken
//   4'hC SETF  flag <= Instruction[0]
//   others     non-control, PC advances
//
// Handshake: there is no valid/ready pair. start is a level request that is
// only sampled in IDLE (to launch) and DONE (to release); it is ignored in
// INIT and RUN. lut_we writes the branch-target table on any clock edge.
//
// Ports
//   CLK          clock, all state updates on posedge
//   reset        synchronous active-high reset
//   start        host run request
//   Instruction  current instruction word from the ROM stage
//   lut_we       branch-target table write enable
//   lut_waddr    table write index
//   lut_wdata    table write data (target PC)
//   init         PC stage init (clears PC to 0 at next edge)
//   branch       PC stage branch
//   jump         PC stage jump (PC loads address when branch & jump)
//   address      branch target to the PC stage
//   done         program finished (halt or watchdog), registered
//   timeout      finish was caused by the watchdog, registered
//   instr_count  non-HALT instructions executed in the current/last run
//   dbg_state_o  current FSM state (0 IDLE, 1 INIT, 2 RUN, 3 DONE)
// ---------------------------------------------------------------------------
module branch_sequencer #(
    parameter logic [15:0] MAX_CYCLES = 16'd50000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  Instruction,
    input  logic        lut_we,
    input  logic [4:0]  lut_waddr,
    input  logic [7:0]  lut_wdata,
    output logic        init,
    output logic        branch,
    output logic        jump,
    output logic [7:0]  address,
    output logic        done,
    output logic        timeout,
    output logic [15:0] instr_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_BR   = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_SETF = 4'hC;

    state_t      state_q;
    logic        flag_q;
    logic [15:0] instr_count_q;
    logic [15:0] instr_count_d;
    logic        done_q;
    logic        timeout_q;
    logic [7:0]  lut_q [32];

    logic [3:0]  opcode;
    logic [4:0]  idx;
    logic        in_run;
    logic        taken;

    assign opcode        = Instruction[8:5];
    assign idx           = Instruction[4:0];
    assign in_run        = (state_q == S_RUN);
    assign instr_count_d = instr_count_q + 16'd1;

    // ------------------------------------------------------------------
    // Branch-target table. Reads are combinational from the registered
    // array, so a read of the index being written this cycle sees the old
    // entry; the new one appears after the edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                lut_q[i] <= 8'h00;
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with its registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= S_IDLE;
            flag_q        <= 1'b0;
            instr_count_q <= 16'd0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    flag_q        <= 1'b0;
                    instr_count_q <= 16'd0;
                    timeout_q     <= 1'b0;
                    state_q       <= S_RUN;
                end
                S_RUN: begin
                    if (opcode == OP_HALT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        instr_count_q <= instr_count_d;
                        if (opcode == OP_SETF) begin
                            flag_q <= Instruction[0];
                        end
                        // Watchdog compares the post-increment count, so the
                        // run stops after exactly MAX_CYCLES instructions.
                        if (instr_count_d == MAX_CYCLES) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Holding start high keeps the result visible; no restart
                    // until the host releases start.
                    if (!start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // PC-stage steering. init is low only in RUN so the PC sits at word 0
    // during INIT and the first RUN cycle presents instruction 0.
    assign taken       = in_run && ((opcode == OP_JMP) || ((opcode == OP_BR) && flag_q));
    assign init        = !in_run;
    assign branch      = taken;
    assign jump        = taken;
    assign address     = in_run ? lut_q[idx] : 8'h00;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign instr_count = instr_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

    localparam logic [15:0] MAXC = 16'd10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  Instruction;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [7:0]  lut_wdata;
    logic        init;
    logic        branch;
    logic        jump;
    logic [7:0]  address;
    logic        done;
    logic        timeout;
    logic [15:0] instr_count;
    logic [1:0]  dbg_state_o;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected run results: {timeout, instr_count}
    logic [16:0] exp_q[$];

    always #5 CLK = ~CLK;

    branch_sequencer #(.MAX_CYCLES(MAXC)) dut (
        .CLK(CLK), .reset(reset), .start(start), .Instruction(Instruction),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .init(init), .branch(branch), .jump(jump), .address(address),
        .done(done), .timeout(timeout), .instr_count(instr_count),
        .dbg_state_o(dbg_state_o)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launch a run: IDLE -> INIT -> RUN, checking each step.
    task automatic start_run();
        start = 1'b1;
        tick();
        checks++; if (dbg_state_o !== ST_INIT) begin failures++; $display("FAIL start_init_state got=%0d exp=%0d", dbg_state_o, ST_INIT); end
        checks++; if (init !== 1'b1) begin failures++; $display("FAIL start_init_init got=%b exp=1", init); end
        start = 1'b0;
        tick();
        checks++; if (dbg_state_o !== ST_RUN) begin failures++; $display("FAIL start_run_state got=%0d exp=%0d", dbg_state_o, ST_RUN); end
        checks++; if (init !== 1'b0) begin failures++; $display("FAIL start_run_init got=%b exp=0", init); end
        checks++; if (instr_count !== 16'd0) begin failures++; $display("FAIL start_run_count got=%0d exp=0", instr_count); end
    endtask

    // Present HALT, wait (bounded) for done, pop and compare the scoreboard.
    task automatic finish_run(input bit hold_start);
        logic [16:0] exp;
        int n;
        Instruction = {4'hF, 5'd0};
        #1;
        checks++; if (branch !== 1'b0) begin failures++; $display("FAIL halt_branch got=%b exp=0", branch); end
        start = hold_start;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++; if (n != 0) begin failures++; $display("FAIL done_latency got=%0d extra cycles exp=0 (done=%b)", n, done); end
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL scoreboard_empty got=empty exp=entry");
        end else begin
            exp = exp_q.pop_front();
            if ({timeout, instr_count} !== exp) begin
                failures++;
                $display("FAIL run_result got=timeout %b count %0d exp=timeout %b count %0d", timeout, instr_count, exp[16], exp[15:0]);
            end
        end
        if (hold_start) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++; if (dbg_state_o !== ST_DONE || done !== 1'b1) begin failures++; $display("FAIL done_hold got=state %0d done %b exp=state 3 done 1", dbg_state_o, done); end
            end
        end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b0 || dbg_state_o !== ST_IDLE || init !== 1'b1) begin failures++; $display("FAIL done_release got=done %b state %0d init %b exp=done 0 state 0 init 1", done, dbg_state_o, init); end
    endtask

    // Run n random non-control words then HALT.
    task automatic run_plain(input int n, input bit hold_start);
        int cnt;
        exp_q.push_back({1'b0, 16'(n)});
        start_run();
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            Instruction = {4'($urandom_range(0, 11)), 5'($urandom_range(0, 31))};
            #1;
            checks++; if (branch !== 1'b0 || jump !== 1'b0) begin failures++; $display("FAIL plain_branch got=%b%b exp=00 instr=%h", branch, jump, Instruction); end
            tick();
            cnt++;
            checks++; if (instr_count !== 16'(cnt)) begin failures++; $display("FAIL plain_count got=%0d exp=%0d", instr_count, cnt); end
        end
        finish_run(hold_start);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; Instruction = 9'd0;
        lut_we = 1'b0; lut_waddr = 5'd0; lut_wdata = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
        checks++; if (init !== 1'b1) begin failures++; $display("FAIL reset_init got=%b exp=1", init); end
        checks++; if (done !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_done_timeout got=%b%b exp=00", done, timeout); end
        checks++; if (instr_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        checks++; if (branch !== 1'b0 || jump !== 1'b0 || address !== 8'h00) begin failures++; $display("FAIL reset_pc_ctl got=%b%b %h exp=00 00", branch, jump, address); end
    endtask

    task automatic test_halt_run();
        run_plain(5, 1'b1);
        checks++; if (instr_count !== 16'd5 || timeout !== 1'b0) begin failures++; $display("FAIL halt_hold_idle got=count %0d timeout %b exp=count 5 timeout 0", instr_count, timeout); end
    endtask

    task automatic test_branch();
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 8'h20;
        tick();
        lut_we = 1'b0;
        // Run A: SETF 1, BR 3 taken
        exp_q.push_back({1'b0, 16'd2});
        start_run();
        Instruction = {4'hC, 5'd1};
        #1;
        checks++; if (branch !== 1'b0) begin failures++; $display("FAIL setf_branch got=%b exp=0", branch); end
        tick();
        Instruction = {4'hE, 5'd3};
        #1;
        checks++; if (branch !== 1'b1 || jump !== 1'b1 || address !== 8'h20) begin failures++; $display("FAIL br_taken got=%b%b %h exp=11 20", branch, jump, address); end
        tick();
        finish_run(1'b0);
        // Run B: flag cleared by INIT, then SETF 1, SETF 0, BR 3 not taken, JMP 3
        exp_q.push_back({1'b0, 16'd5});
        start_run();
        Instruction = {4'hE, 5'd3};
        #1;
        checks++; if (branch !== 1'b0 || jump !== 1'b0) begin failures++; $display("FAIL br_after_init got=%b%b exp=00", branch, jump); end
        tick();
        Instruction = {4'hC, 5'd1};
        tick();
        Instruction = {4'hC, 5'd0};
        tick();
        Instruction = {4'hE, 5'd3};
        #1;
        checks++; if (branch !== 1'b0 || jump !== 1'b0 || address !== 8'h20) begin failures++; $display("FAIL br_not_taken got=%b%b %h exp=00 20", branch, jump, address); end
        tick();
        Instruction = {4'hD, 5'd3};
        #1;
        checks++; if (branch !== 1'b1 || jump !== 1'b1 || address !== 8'h20) begin failures++; $display("FAIL jmp_taken got=%b%b %h exp=11 20", branch, jump, address); end
        tick();
        finish_run(1'b0);
    endtask

    task automatic test_jump_timeout();
        logic [16:0] exp;
        int cycles;
        exp_q.push_back({1'b1, MAXC});
        start_run();
        Instruction = {4'hD, 5'd3};
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            #1;
            checks++; if (branch !== 1'b1 || address !== 8'h20) begin failures++; $display("FAIL jmp_self got=%b %h exp=1 20 cycle %0d", branch, address, cycles); end
            tick();
            cycles++;
        end
        checks++; if (cycles != int'(MAXC)) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d (done=%b)", cycles, MAXC, done); end
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL scoreboard_empty got=empty exp=entry");
        end else begin
            exp = exp_q.pop_front();
            if ({timeout, instr_count} !== exp) begin
                failures++;
                $display("FAIL timeout_result got=timeout %b count %0d exp=timeout %b count %0d", timeout, instr_count, exp[16], exp[15:0]);
            end
        end
        start = 1'b0;
        tick();
        checks++; if (dbg_state_o !== ST_IDLE || timeout !== 1'b1 || instr_count !== MAXC) begin failures++; $display("FAIL timeout_hold got=state %0d timeout %b count %0d exp=state 0 timeout 1 count %0d", dbg_state_o, timeout, instr_count, MAXC); end
    endtask

    task automatic test_same_cycle_write();
        lut_we = 1'b1; lut_waddr = 5'd7; lut_wdata = 8'h11;
        tick();
        lut_we = 1'b0;
        exp_q.push_back({1'b0, 16'd2});
        start_run();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL init_clears_timeout got=%b exp=0", timeout); end
        Instruction = {4'h0, 5'd7};
        lut_we = 1'b1; lut_waddr = 5'd7; lut_wdata = 8'h5A;
        #1;
        checks++; if (address !== 8'h11) begin failures++; $display("FAIL rw_same_cycle got=%h exp=11", address); end
        tick();
        lut_we = 1'b0;
        #1;
        checks++; if (address !== 8'h5A) begin failures++; $display("FAIL rw_next_cycle got=%h exp=5a", address); end
        tick();
        finish_run(1'b0);
    endtask

    task automatic test_reset_mid_run();
        // Reset beats start and lut_we in the same cycle
        reset = 1'b1; start = 1'b1; lut_we = 1'b1; lut_waddr = 5'd9; lut_wdata = 8'hFF;
        tick();
        reset = 1'b0; start = 1'b0; lut_we = 1'b0;
        checks++; if (dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL reset_over_start got=%0d exp=0", dbg_state_o); end
        start_run();
        for (int i = 0; i < 4; i++) begin
            Instruction = {4'h1, 5'(i)};
            tick();
        end
        checks++; if (instr_count !== 16'd4) begin failures++; $display("FAIL pre_reset_count got=%0d exp=4", instr_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (dbg_state_o !== ST_IDLE || instr_count !== 16'd0 || done !== 1'b0 || init !== 1'b1) begin failures++; $display("FAIL mid_run_reset got=state %0d count %0d done %b init %b exp=state 0 count 0 done 0 init 1", dbg_state_o, instr_count, done, init); end
        // Table contents were cleared and the blocked write never landed
        exp_q.push_back({1'b0, 16'd2});
        start_run();
        Instruction = {4'h0, 5'd9};
        #1;
        checks++; if (address !== 8'h00) begin failures++; $display("FAIL lut9_after_reset got=%h exp=00", address); end
        tick();
        Instruction = {4'h0, 5'd3};
        #1;
        checks++; if (address !== 8'h00) begin failures++; $display("FAIL lut3_after_reset got=%h exp=00", address); end
        tick();
        finish_run(1'b0);
    endtask

    task automatic test_random_runs();
        run_plain(0, 1'b0);
        run_plain(int'(MAXC) - 1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_plain($urandom_range(1, 9), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_halt_run();
        test_branch();
        test_jump_timeout();
        test_same_cycle_write();
        test_reset_mid_run();
        test_random_runs();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
